// File: rtl/axi_lite_regfile_slv.sv
// AXI4-Lite register-file slave: byte-strobe writes, read-only masking,
// independent single-outstanding read and write engines.
package axi_lite_regfile_pkg;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef struct packed {
        logic [31:0] addr;
        logic [2:0]  prot;
    } ax_chan_t;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  strb;
    } w_chan_t;

    typedef struct packed {
        logic [1:0] resp;
    } b_chan_t;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
    } r_chan_t;

    typedef struct packed {
        ax_chan_t aw;
        logic     aw_valid;
        w_chan_t  w;
        logic     w_valid;
        logic     b_ready;
        ax_chan_t ar;
        logic     ar_valid;
        logic     r_ready;
    } req_t;

    typedef struct packed {
        logic    aw_ready;
        logic    w_ready;
        b_chan_t b;
        logic    b_valid;
        logic    ar_ready;
        r_chan_t r;
        logic    r_valid;
    } resp_t;
endpackage

module axi_lite_regfile_slv
    import axi_lite_regfile_pkg::*;
#(
    parameter int unsigned            AxiAddrWidth = 32,
    parameter int unsigned            AxiDataWidth = 32,
    parameter int unsigned            NoRegs       = 8,
    parameter logic [NoRegs-1:0]      ReadOnly     = '0,
    parameter logic [AxiDataWidth-1:0] RegRstVal   = '0,
    parameter type                    req_t        = axi_lite_regfile_pkg::req_t,
    parameter type                    resp_t       = axi_lite_regfile_pkg::resp_t
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  req_t                             slv_req_i,
    output resp_t                            slv_resp_o,
    input  logic [AxiAddrWidth-1:0]          base_addr_i,
    input  logic [NoRegs*AxiDataWidth-1:0]   reg_d_i,
    output logic [NoRegs*AxiDataWidth-1:0]   reg_q_o,
    output logic [NoRegs-1:0]                wr_pulse_o,
    output logic [NoRegs-1:0]                rd_pulse_o
);
    localparam int unsigned StrbWidth = AxiDataWidth / 8;
    localparam int unsigned AddrLsb   = $clog2(StrbWidth);
    localparam int unsigned IdxWidth  = (NoRegs > 1) ? $clog2(NoRegs) : 1;

    typedef logic [AxiDataWidth-1:0] word_t;

    logic                    live_q;
    logic                    aw_full_q, w_full_q, b_valid_q;
    logic [AxiAddrWidth-1:0] aw_addr_q;
    word_t                   w_data_q;
    logic [StrbWidth-1:0]    w_strb_q;
    logic [1:0]              b_resp_q;
    logic                    r_valid_q;
    word_t                   r_data_q;
    logic [1:0]              r_resp_q;
    logic [NoRegs-1:0]       wr_pulse_q, rd_pulse_q;
    word_t [NoRegs-1:0]      regs_q, q_all, d_all;

    logic                    aw_ready, w_ready, ar_ready;
    logic                    aw_hs, w_hs, ar_hs, commit;
    logic [AxiAddrWidth-1:0] aw_word, ar_word;
    logic                    aw_hit, ar_hit;
    logic [IdxWidth-1:0]     aw_idx, ar_idx;
    logic                    unused_prot;

    assign unused_prot = ^{slv_req_i.aw.prot, slv_req_i.ar.prot};

    assign d_all = reg_d_i;
    for (genvar k = 0; k < NoRegs; k++) begin : g_q
        assign q_all[k] = ReadOnly[k] ? d_all[k] : regs_q[k];
    end
    assign reg_q_o    = q_all;
    assign wr_pulse_o = wr_pulse_q;
    assign rd_pulse_o = rd_pulse_q;

    // Ready stays low during reset, so it is gated by a post-reset flag.
    assign aw_ready = live_q && !aw_full_q;
    assign w_ready  = live_q && !w_full_q;
    assign ar_ready = live_q && !r_valid_q;
    assign aw_hs    = slv_req_i.aw_valid && aw_ready;
    assign w_hs     = slv_req_i.w_valid && w_ready;
    assign ar_hs    = slv_req_i.ar_valid && ar_ready;
    assign commit   = aw_full_q && w_full_q && !b_valid_q;

    assign aw_word = (aw_addr_q - base_addr_i) >> AddrLsb;
    assign aw_hit  = (aw_addr_q >= base_addr_i) &&
                     (aw_word < AxiAddrWidth'(NoRegs));
    assign aw_idx  = aw_word[IdxWidth-1:0];

    assign ar_word = (slv_req_i.ar.addr - base_addr_i) >> AddrLsb;
    assign ar_hit  = (slv_req_i.ar.addr >= base_addr_i) &&
                     (ar_word < AxiAddrWidth'(NoRegs));
    assign ar_idx  = ar_word[IdxWidth-1:0];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            live_q     <= 1'b0;
            aw_full_q  <= 1'b0;
            w_full_q   <= 1'b0;
            aw_addr_q  <= '0;
            w_data_q   <= '0;
            w_strb_q   <= '0;
            b_valid_q  <= 1'b0;
            b_resp_q   <= '0;
            wr_pulse_q <= '0;
            regs_q     <= {NoRegs{RegRstVal}};
        end else begin
            live_q     <= 1'b1;
            wr_pulse_q <= '0;
            if (aw_hs) begin
                aw_full_q <= 1'b1;
                aw_addr_q <= slv_req_i.aw.addr;
            end
            if (w_hs) begin
                w_full_q <= 1'b1;
                w_data_q <= slv_req_i.w.data;
                w_strb_q <= slv_req_i.w.strb;
            end
            if (b_valid_q && slv_req_i.b_ready) begin
                b_valid_q <= 1'b0;
            end
            if (commit) begin
                aw_full_q <= 1'b0;
                w_full_q  <= 1'b0;
                b_valid_q <= 1'b1;
                if (!aw_hit) begin
                    b_resp_q <= RESP_DECERR;
                end else if (ReadOnly[aw_idx]) begin
                    b_resp_q <= RESP_SLVERR;
                end else begin
                    b_resp_q           <= RESP_OKAY;
                    wr_pulse_q[aw_idx] <= 1'b1;
                    for (int b = 0; b < StrbWidth; b++) begin
                        if (w_strb_q[b]) begin
                            regs_q[aw_idx][8*b +: 8] <= w_data_q[8*b +: 8];
                        end
                    end
                end
            end
        end
    end

    // Sampling q_all here gives the pre-commit value on a same-cycle write.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_valid_q  <= 1'b0;
            r_data_q   <= '0;
            r_resp_q   <= '0;
            rd_pulse_q <= '0;
        end else begin
            rd_pulse_q <= '0;
            if (ar_hs) begin
                r_valid_q <= 1'b1;
                if (ar_hit) begin
                    r_data_q           <= q_all[ar_idx];
                    r_resp_q           <= RESP_OKAY;
                    rd_pulse_q[ar_idx] <= 1'b1;
                end else begin
                    r_data_q <= '0;
                    r_resp_q <= RESP_DECERR;
                end
            end else if (r_valid_q && slv_req_i.r_ready) begin
                r_valid_q <= 1'b0;
            end
        end
    end

    always_comb begin
        slv_resp_o          = '0;
        slv_resp_o.aw_ready = aw_ready;
        slv_resp_o.w_ready  = w_ready;
        slv_resp_o.b.resp   = b_resp_q;
        slv_resp_o.b_valid  = b_valid_q;
        slv_resp_o.ar_ready = ar_ready;
        slv_resp_o.r.data   = r_data_q;
        slv_resp_o.r.resp   = r_resp_q;
        slv_resp_o.r_valid  = r_valid_q;
    end
endmodule

// File: tb/tb_axi_lite_regfile_slv.sv
// Directed bench for axi_lite_regfile_slv with B/R scoreboard queues.
module tb_axi_lite_regfile_slv;
    import axi_lite_regfile_pkg::*;

    localparam logic [31:0] BASE = 32'h4000_1000;
    localparam logic [31:0] RST  = 32'h1111_2222;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    req_t          req;
    resp_t         resp;
    logic [31:0]   base = BASE;
    logic [255:0]  reg_d;
    logic [255:0]  reg_q;
    logic [7:0]    wr_pulse, rd_pulse;

    int checks = 0;
    int errors = 0;
    logic [1:0]  bq[$];
    logic [33:0] rq[$];
    logic [7:0]  pulse;

    always #5 clk = ~clk;

    axi_lite_regfile_slv #(
        .AxiAddrWidth(32),
        .AxiDataWidth(32),
        .NoRegs(8),
        .ReadOnly(8'h01),
        .RegRstVal(RST)
    ) dut (
        .clk_i(clk),
        .rst_ni(rst_n),
        .slv_req_i(req),
        .slv_resp_o(resp),
        .base_addr_i(base),
        .reg_d_i(reg_d),
        .reg_q_o(reg_q),
        .wr_pulse_o(wr_pulse),
        .rd_pulse_o(rd_pulse)
    );

    function automatic logic [31:0] rq_word(input int k);
        return reg_q[k*32 +: 32];
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_b();
        int n = 0;
        logic [1:0] exp;
        while (!resp.b_valid && n < 50) begin
            step();
            n++;
        end
        if (!resp.b_valid) begin
            chk("b_timeout", 0, 1);
            return;
        end
        if (bq.size() == 0) begin
            chk("b_unexpected", 1, 0);
        end else begin
            exp = bq.pop_front();
            chk("b_resp", 64'(resp.b.resp), 64'(exp));
        end
        req.b_ready = 1'b1;
        step();
        req.b_ready = 1'b0;
    endtask

    task automatic wait_r();
        int n = 0;
        logic [33:0] exp;
        while (!resp.r_valid && n < 50) begin
            step();
            n++;
        end
        if (!resp.r_valid) begin
            chk("r_timeout", 0, 1);
            return;
        end
        if (rq.size() == 0) begin
            chk("r_unexpected", 1, 0);
        end else begin
            exp = rq.pop_front();
            chk("r_data_resp", 64'({resp.r.resp, resp.r.data}), 64'(exp));
        end
        req.r_ready = 1'b1;
        step();
        req.r_ready = 1'b0;
    endtask

    task automatic write_txn(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input logic [1:0] exp,
                             output logic [7:0] wp);
        int n = 0;
        bq.push_back(exp);
        req.aw.addr  = addr;
        req.w.data   = data;
        req.w.strb   = strb;
        req.aw_valid = 1'b1;
        req.w_valid  = 1'b1;
        while (!(resp.aw_ready && resp.w_ready) && n < 50) begin
            step();
            n++;
        end
        if (n == 50) chk("aw_w_timeout", 0, 1);
        step();
        req.aw_valid = 1'b0;
        req.w_valid  = 1'b0;
        chk("b_early", 64'(resp.b_valid), 0);
        step();
        chk("b_latency", 64'(resp.b_valid), 1);
        wp = wr_pulse;
        wait_b();
    endtask

    task automatic read_txn(input logic [31:0] addr, input logic [31:0] data,
                            input logic [1:0] exp, output logic [7:0] rp);
        int n = 0;
        rq.push_back({exp, data});
        req.ar.addr  = addr;
        req.ar_valid = 1'b1;
        while (!resp.ar_ready && n < 50) begin
            step();
            n++;
        end
        if (n == 50) chk("ar_timeout", 0, 1);
        step();
        req.ar_valid = 1'b0;
        chk("r_latency", 64'(resp.r_valid), 1);
        rp = rd_pulse;
        wait_r();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        req = '0;
        for (int k = 0; k < 8; k++) reg_d[k*32 +: 32] = 32'hBAD0_0000 | k;
        reg_d[31:0] = 32'hCAFE_0000;

        // Reset state
        step();
        step();
        chk("rst_hs", 64'({resp.aw_ready, resp.w_ready, resp.ar_ready,
                           resp.b_valid, resp.r_valid}), 0);
        chk("rst_payload", 64'({resp.b.resp, resp.r.resp, resp.r.data}), 0);
        chk("rst_pulses", 64'({wr_pulse, rd_pulse}), 0);
        chk("rst_reg1", 64'(rq_word(1)), 64'(RST));
        chk("rst_ro_mirror", 64'(rq_word(0)), 64'h0CAFE_0000);
        rst_n = 1'b1;
        step();
        chk("ready_after_rst", 64'({resp.aw_ready, resp.w_ready,
                                     resp.ar_ready}), 64'b111);

        // Full-word write, AW and W together
        write_txn(BASE + 32'h4, 32'hDEAD_BEEF, 4'hF, RESP_OKAY, pulse);
        chk("wr1_pulse", 64'(pulse), 64'h02);
        chk("wr1_reg1", 64'(rq_word(1)), 64'hDEAD_BEEF);
        chk("wr1_pulse_gone", 64'(wr_pulse), 0);

        // W two cycles ahead of AW, partial strobe
        write_txn(BASE + 32'h8, 32'hAAAA_AAAA, 4'hF, RESP_OKAY, pulse);
        bq.push_back(RESP_OKAY);
        req.w.data  = 32'h1234_5678;
        req.w.strb  = 4'h3;
        req.w_valid = 1'b1;
        step();
        chk("w_slot_full", 64'({resp.w_ready, resp.aw_ready}), 64'b01);
        req.w.data = 32'hFFFF_FFFF;
        req.w.strb = 4'hF;
        step();
        chk("w_block1", 64'(resp.w_ready), 0);
        step();
        chk("w_block2", 64'(resp.w_ready), 0);
        req.w_valid  = 1'b0;
        req.aw.addr  = BASE + 32'h8;
        req.aw_valid = 1'b1;
        step();
        req.aw_valid = 1'b0;
        wait_b();
        chk("wr2_reg2", 64'(rq_word(2)), 64'hAAAA_5678);

        // Read-only register
        write_txn(BASE, 32'h1111_1111, 4'hF, RESP_SLVERR, pulse);
        chk("ro_wr_pulse", 64'(pulse), 0);
        chk("ro_reg0", 64'(rq_word(0)), 64'hCAFE_0000);
        read_txn(BASE, 32'hCAFE_0000, RESP_OKAY, pulse);
        chk("ro_rd_pulse", 64'(pulse), 64'h01);
        chk("rd_pulse_gone", 64'(rd_pulse), 0);

        // Out of range and alignment boundaries
        read_txn(BASE + 32'd32, 32'h0, RESP_DECERR, pulse);
        chk("oor_hi_rd_pulse", 64'(pulse), 0);
        read_txn(BASE - 32'd4, 32'h0, RESP_DECERR, pulse);
        chk("oor_lo_rd_pulse", 64'(pulse), 0);
        write_txn(BASE + 32'd32, 32'h9999_9999, 4'hF, RESP_DECERR, pulse);
        chk("oor_hi_wr_pulse", 64'(pulse), 0);
        write_txn(BASE - 32'd4, 32'h9999_9999, 4'hF, RESP_DECERR, pulse);
        chk("oor_lo_wr_pulse", 64'(pulse), 0);
        read_txn(BASE + 32'h6, 32'hDEAD_BEEF, RESP_OKAY, pulse);
        chk("unaligned_rd_pulse", 64'(pulse), 64'h02);
        write_txn(BASE + 32'h1C, 32'hFFFF_FFFF, 4'h0, RESP_OKAY, pulse);
        chk("strb0_pulse", 64'(pulse), 64'h80);
        chk("strb0_reg7", 64'(rq_word(7)), 64'(RST));
        read_txn(BASE + 32'h1C, RST, RESP_OKAY, pulse);
        chk("last_rd_pulse", 64'(pulse), 64'h80);

        // Same-register collision: read in commit cycle sees old value
        bq.push_back(RESP_OKAY);
        rq.push_back({RESP_OKAY, RST});
        req.aw.addr  = BASE + 32'h18;
        req.w.data   = 32'h7777_7777;
        req.w.strb   = 4'hF;
        req.aw_valid = 1'b1;
        req.w_valid  = 1'b1;
        step();
        req.aw_valid = 1'b0;
        req.w_valid  = 1'b0;
        req.ar.addr  = BASE + 32'h18;
        req.ar_valid = 1'b1;
        step();
        req.ar_valid = 1'b0;
        wait_b();
        wait_r();
        read_txn(BASE + 32'h18, 32'h7777_7777, RESP_OKAY, pulse);

        // Backpressure on B and R
        rq.push_back({RESP_OKAY, 32'hDEAD_BEEF});
        req.ar.addr  = BASE + 32'h4;
        req.ar_valid = 1'b1;
        step();
        req.ar_valid = 1'b0;
        bq.push_back(RESP_OKAY);
        req.aw.addr  = BASE + 32'hC;
        req.w.data   = 32'h3333_3333;
        req.aw_valid = 1'b1;
        req.w_valid  = 1'b1;
        step();
        req.aw.addr = BASE + 32'h10;
        req.w.data  = 32'h4444_4444;
        step();
        bq.push_back(RESP_OKAY);
        req.ar.addr  = BASE + 32'h8;
        req.ar_valid = 1'b1;
        step();
        req.aw_valid = 1'b0;
        req.w_valid  = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("stall_state",
                64'({resp.b_valid, resp.b.resp, resp.r_valid, resp.r.data,
                     resp.aw_ready, resp.w_ready, resp.ar_ready}),
                64'({1'b1, RESP_OKAY, 1'b1, 32'hDEAD_BEEF, 3'b000}));
            chk("stall_reg4", 64'(rq_word(4)), 64'(RST));
            step();
        end
        req.ar_valid = 1'b0;
        wait_b();
        wait_b();
        wait_r();
        chk("stall_reg3", 64'(rq_word(3)), 64'h3333_3333);
        chk("stall_reg4_after", 64'(rq_word(4)), 64'h4444_4444);

        // Reset with AW accepted and W outstanding
        req.aw.addr  = BASE + 32'h14;
        req.aw_valid = 1'b1;
        step();
        req.aw_valid = 1'b0;
        chk("mid_aw_held", 64'(resp.aw_ready), 0);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_hs", 64'({resp.aw_ready, resp.w_ready, resp.ar_ready,
                               resp.b_valid, resp.r_valid}), 0);
        chk("mid_rst_reg1", 64'(rq_word(1)), 64'(RST));
        step();
        step();
        rst_n = 1'b1;
        step();
        step();
        req.w.data  = 32'h55AA_55AA;
        req.w.strb  = 4'hF;
        req.w_valid = 1'b1;
        step();
        req.w_valid = 1'b0;
        step();
        step();
        chk("stale_aw_dropped", 64'(resp.b_valid), 0);
        bq.push_back(RESP_OKAY);
        req.aw.addr  = BASE + 32'h14;
        req.aw_valid = 1'b1;
        step();
        req.aw_valid = 1'b0;
        wait_b();
        read_txn(BASE + 32'h14, 32'h55AA_55AA, RESP_OKAY, pulse);
        read_txn(BASE + 32'h4, RST, RESP_OKAY, pulse);
        read_txn(BASE + 32'hC, RST, RESP_OKAY, pulse);
        chk("sb_empty", 64'({bq.size() == 0, rq.size() == 0}), 64'b11);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
